cluster_resp_collect: RTL and testbench

// - Gathers the per-cluster accelerator responses from NrClusters Ara macros and merges them into
//   one response toward CVA6. This is the response-side counterpart of the request fork.
// - A response is released only once every cluster has answered the same instruction.
// - Sits between the ara_macro instances and the CVA6 acc_resp port in the cluster top.

---
 rtl/cluster_resp_collect_pkg.sv | 22 ++
 rtl/cluster_resp_collect.sv | 148 ++++++++++++++
 tb/tb_cluster_resp_collect.sv | 206 ++++++++++++++++++++
 3 files changed

// File: rtl/cluster_resp_collect_pkg.sv
// Shared types and helpers for merging per-cluster accelerator responses
// into a single response toward the scalar core.
package cluster_resp_collect_pkg;

  localparam int unsigned MaxNrClusters   = 16;
  localparam int unsigned MaxIdxWidth     = $clog2(MaxNrClusters);
  localparam int unsigned RespFflagsWidth = 5;

  typedef enum logic {
    ST_COLLECT = 1'b0,
    ST_PRESENT = 1'b1
  } collect_state_e;

  // Index of the lowest set bit; 0 when the vector is empty.
  function automatic logic [MaxIdxWidth-1:0] trailing_zero_idx(input logic [MaxNrClusters-1:0] v);
    trailing_zero_idx = '0;
    for (int i = MaxNrClusters - 1; i >= 0; i--) begin
      if (v[i]) trailing_zero_idx = MaxIdxWidth'(i);
    end
  endfunction

endpackage

// File: rtl/cluster_resp_collect.sv
// Collects one response per cluster for the same instruction, then presents a
// single merged response; flags id disagreement and stalled partial collections.
module cluster_resp_collect
  import cluster_resp_collect_pkg::*;
#(
  parameter int unsigned NrClusters    = 4,
  parameter int unsigned DataWidth     = 64,
  parameter int unsigned TransIdWidth  = 3,
  parameter int unsigned ResultCluster = 0,
  parameter int unsigned TimeoutCycles = 1024,
  localparam int unsigned IdxWidth     = (NrClusters > 1) ? $clog2(NrClusters) : 1
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic [NrClusters-1:0]                 clus_valid_i,
  output logic [NrClusters-1:0]                 clus_ready_o,
  input  logic [NrClusters*DataWidth-1:0]       clus_result_i,
  input  logic [NrClusters*TransIdWidth-1:0]    clus_trans_id_i,
  input  logic [NrClusters-1:0]                 clus_exc_i,
  input  logic [NrClusters*RespFflagsWidth-1:0] clus_fflags_i,
  output logic                                  resp_valid_o,
  input  logic                                  resp_ready_i,
  output logic [DataWidth-1:0]                  result_o,
  output logic [TransIdWidth-1:0]               trans_id_o,
  output logic                                  exc_o,
  output logic [IdxWidth-1:0]                   exc_cluster_o,
  output logic [RespFflagsWidth-1:0]            fflags_o,
  output logic                                  mismatch_o,
  output logic                                  timeout_o
);

  localparam int unsigned CntWidth = (TimeoutCycles > 0) ? $clog2(TimeoutCycles + 1) : 1;

  typedef struct packed {
    logic [DataWidth-1:0]       result;
    logic [TransIdWidth-1:0]    trans_id;
    logic                       exc;
    logic [RespFflagsWidth-1:0] fflags;
  } cluster_resp_t;

  collect_state_e        r_state;
  logic [NrClusters-1:0] r_got;
  cluster_resp_t         r_slot [NrClusters];
  logic [CntWidth-1:0]   r_wdog;
  logic                  r_resp_valid;
  logic                  r_mismatch;
  logic                  r_timeout;

  cluster_resp_t          w_slot_in [NrClusters];
  logic [NrClusters-1:0]  w_cap;
  logic [NrClusters-1:0]  w_got_next;
  logic                   w_all_got;
  logic                   w_id_diff;
  logic [CntWidth-1:0]    w_wdog_inc;
  logic [NrClusters-1:0]  w_exc_vec;
  logic [MaxIdxWidth-1:0] w_exc_idx;
  logic [RespFflagsWidth-1:0] w_fflags_or;
  logic                   w_unused;

  assign clus_ready_o = (r_state == ST_COLLECT) ? ~r_got : '0;
  assign w_cap        = clus_valid_i & clus_ready_o;
  assign w_got_next   = r_got | w_cap;
  assign w_all_got    = &w_got_next;
  assign w_wdog_inc   = (r_wdog == '1) ? r_wdog : r_wdog + 1'b1;

  // The id comparison uses the values the slots will hold after this edge.
  always_comb begin
    w_id_diff   = 1'b0;
    w_fflags_or = '0;
    w_unused    = 1'b0;
    for (int c = 0; c < NrClusters; c++) begin
      w_slot_in[c].result   = clus_result_i[c*DataWidth +: DataWidth];
      w_slot_in[c].trans_id = clus_trans_id_i[c*TransIdWidth +: TransIdWidth];
      w_slot_in[c].exc      = clus_exc_i[c];
      w_slot_in[c].fflags   = clus_fflags_i[c*RespFflagsWidth +: RespFflagsWidth];
      w_exc_vec[c]          = r_slot[c].exc;
      w_fflags_or           = w_fflags_or | r_slot[c].fflags;
      w_unused              = w_unused ^ (^r_slot[c].result);
    end
    for (int c = 1; c < NrClusters; c++) begin
      if ((w_cap[c] ? w_slot_in[c].trans_id : r_slot[c].trans_id) !=
          (w_cap[0] ? w_slot_in[0].trans_id : r_slot[0].trans_id))
        w_id_diff = 1'b1;
    end
    w_exc_idx = trailing_zero_idx(MaxNrClusters'(w_exc_vec));
    w_unused  = w_unused ^ (^w_exc_idx);
  end

  // NOTE: the slots are reset because they drive the response outputs directly.
  for (genvar c = 0; c < NrClusters; c++) begin : g_slot
    always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i)         r_slot[c] <= '0;
      else if (w_cap[c]) r_slot[c] <= w_slot_in[c];
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_state      <= ST_COLLECT;
      r_got        <= '0;
      r_wdog       <= '0;
      r_resp_valid <= 1'b0;
      r_mismatch   <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      case (r_state)
        ST_COLLECT: begin
          r_got <= w_got_next;
          if (w_all_got) begin
            r_state      <= ST_PRESENT;
            r_resp_valid <= 1'b1;
            r_wdog       <= '0;
            if (w_id_diff) r_mismatch <= 1'b1;
          end else if (|w_cap) begin
            r_wdog <= '0;
          end else if ((|r_got) && (TimeoutCycles != 0)) begin
            if (w_wdog_inc == CntWidth'(TimeoutCycles)) begin
              r_timeout <= 1'b1;
              r_wdog    <= '0;
            end else begin
              r_wdog <= w_wdog_inc;
            end
          end
        end
        ST_PRESENT: begin
          if (resp_ready_i) begin
            r_state      <= ST_COLLECT;
            r_got        <= '0;
            r_resp_valid <= 1'b0;
            r_wdog       <= '0;
          end
        end
        default: r_state <= ST_COLLECT;
      endcase
    end
  end

  assign resp_valid_o  = r_resp_valid;
  assign result_o      = r_slot[ResultCluster].result;
  assign trans_id_o    = r_slot[0].trans_id;
  assign exc_o         = |w_exc_vec;
  assign exc_cluster_o = w_exc_idx[IdxWidth-1:0];
  assign fflags_o      = w_fflags_or;
  assign mismatch_o    = r_mismatch;
  assign timeout_o     = r_timeout;

endmodule

// File: tb/tb_cluster_resp_collect.sv
// Directed bench for cluster_resp_collect: 4 clusters, 16-cycle watchdog.
module tb_cluster_resp_collect;

  localparam int unsigned NC = 4;
  localparam int unsigned DW = 64;
  localparam int unsigned TW = 3;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic [NC-1:0]   clus_valid_i;
  logic [NC-1:0]   clus_ready_o;
  logic [NC*DW-1:0] clus_result_i;
  logic [NC*TW-1:0] clus_trans_id_i;
  logic [NC-1:0]   clus_exc_i;
  logic [NC*5-1:0] clus_fflags_i;
  logic            resp_valid_o;
  logic            resp_ready_i;
  logic [DW-1:0]   result_o;
  logic [TW-1:0]   trans_id_o;
  logic            exc_o;
  logic [1:0]      exc_cluster_o;
  logic [4:0]      fflags_o;
  logic            mismatch_o;
  logic            timeout_o;

  int n_vec = 0;
  int n_err = 0;

  cluster_resp_collect #(
    .NrClusters(NC), .DataWidth(DW), .TransIdWidth(TW),
    .ResultCluster(0), .TimeoutCycles(16)
  ) dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .clus_valid_i(clus_valid_i), .clus_ready_o(clus_ready_o),
    .clus_result_i(clus_result_i), .clus_trans_id_i(clus_trans_id_i),
    .clus_exc_i(clus_exc_i), .clus_fflags_i(clus_fflags_i),
    .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i),
    .result_o(result_o), .trans_id_o(trans_id_o),
    .exc_o(exc_o), .exc_cluster_o(exc_cluster_o), .fflags_o(fflags_o),
    .mismatch_o(mismatch_o), .timeout_o(timeout_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic set_slot(input int c, input logic [DW-1:0] res, input logic [TW-1:0] id,
                          input logic exc, input logic [4:0] ff);
    clus_result_i[c*DW +: DW]  = res;
    clus_trans_id_i[c*TW +: TW] = id;
    clus_exc_i[c]              = exc;
    clus_fflags_i[c*5 +: 5]    = ff;
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic handshake();
    resp_ready_i = 1'b1;
    tick();
    resp_ready_i = 1'b0;
  endtask

  task automatic all_respond(input logic [2:0] id0, input logic [2:0] id1,
                             input logic [2:0] id2, input logic [2:0] id3);
    set_slot(0, 64'hA0, id0, 1'b0, 5'h00);
    set_slot(1, 64'hA1, id1, 1'b0, 5'h00);
    set_slot(2, 64'hA2, id2, 1'b0, 5'h00);
    set_slot(3, 64'hA3, id3, 1'b0, 5'h00);
    clus_valid_i = 4'hF;
    tick();
    clus_valid_i = 4'h0;
  endtask

  initial begin
    rst_i = 1'b1;
    clus_valid_i = '0; clus_result_i = '0; clus_trans_id_i = '0;
    clus_exc_i = '0; clus_fflags_i = '0; resp_ready_i = 1'b0;
    tick(); tick();
    check("rst_valid", resp_valid_o, 0);
    check("rst_result", result_o, 0);
    check("rst_mismatch", mismatch_o, 0);
    check("rst_timeout", timeout_o, 0);
    rst_i = 1'b0;
    tick();
    check("idle_ready", clus_ready_o, 4'hF);

    // All four clusters answer in the same cycle.
    set_slot(0, 64'h1111_0000_0000_0001, 3'd5, 1'b0, 5'h00);
    set_slot(1, 64'h2222_0000_0000_0002, 3'd5, 1'b0, 5'h00);
    set_slot(2, 64'h3333_0000_0000_0003, 3'd5, 1'b0, 5'h00);
    set_slot(3, 64'h4444_0000_0000_0004, 3'd5, 1'b0, 5'h00);
    clus_valid_i = 4'hF;
    tick();
    clus_valid_i = 4'h0;
    check("t1_valid", resp_valid_o, 1);
    check("t1_result", result_o, 64'h1111_0000_0000_0001);
    check("t1_id", trans_id_o, 5);
    check("t1_ready", clus_ready_o, 4'h0);
    check("t1_exc", exc_o, 0);
    handshake();
    check("t1_drop", resp_valid_o, 0);
    check("t1_ready_back", clus_ready_o, 4'hF);

    // Staggered answers at cycles 0,3,7,9.
    for (int k = 0; k < 10; k++) begin
      clus_valid_i = 4'h0;
      if (k == 0) begin set_slot(0, 64'hB0, 3'd2, 1'b0, 5'h00); clus_valid_i[0] = 1'b1; end
      if (k == 3) begin set_slot(1, 64'hB1, 3'd2, 1'b0, 5'h00); clus_valid_i[1] = 1'b1; end
      if (k == 7) begin set_slot(2, 64'hB2, 3'd2, 1'b0, 5'h00); clus_valid_i[2] = 1'b1; end
      if (k == 9) begin set_slot(3, 64'hB3, 3'd2, 1'b0, 5'h00); clus_valid_i[3] = 1'b1; end
      check($sformatf("t2_novalid_c%0d", k), resp_valid_o, 0);
      tick();
      clus_valid_i = 4'h0;
      if (k == 0) check("t2_ready_c0", clus_ready_o, 4'b1110);
      if (k == 3) check("t2_ready_c3", clus_ready_o, 4'b1100);
      if (k == 7) check("t2_ready_c7", clus_ready_o, 4'b1000);
    end
    check("t2_valid_c10", resp_valid_o, 1);
    check("t2_result", result_o, 64'hB0);

    // Back-pressure: payload holds, nothing else is captured.
    for (int k = 0; k < 6; k++) begin
      if (k == 2) begin
        set_slot(0, 64'hDEAD, 3'd7, 1'b1, 5'h1F);
        clus_valid_i = 4'h1;
      end else begin
        clus_valid_i = 4'h0;
      end
      tick();
      check($sformatf("t3_valid_%0d", k), resp_valid_o, 1);
      check($sformatf("t3_result_%0d", k), result_o, 64'hB0);
      check($sformatf("t3_ready_%0d", k), clus_ready_o, 4'h0);
      check($sformatf("t3_exc_%0d", k), exc_o, 0);
    end
    clus_valid_i = 4'h0;
    check("t3_id", trans_id_o, 2);
    handshake();
    check("t3_drop", resp_valid_o, 0);

    // Exception merge.
    set_slot(0, 64'hC0, 3'd5, 1'b0, 5'h00);
    set_slot(1, 64'hC1, 3'd5, 1'b1, 5'h01);
    set_slot(2, 64'hC2, 3'd5, 1'b1, 5'h04);
    set_slot(3, 64'hC3, 3'd5, 1'b0, 5'h00);
    clus_valid_i = 4'hF;
    tick();
    clus_valid_i = 4'h0;
    check("t4_exc", exc_o, 1);
    check("t4_exc_cluster", exc_cluster_o, 1);
    check("t4_fflags", fflags_o, 5'h05);
    check("t4_mismatch", mismatch_o, 0);
    handshake();

    // Id disagreement from cluster 2.
    all_respond(3'd5, 3'd5, 3'd6, 3'd5);
    check("t5_valid", resp_valid_o, 1);
    check("t5_id", trans_id_o, 5);
    check("t5_mismatch", mismatch_o, 1);
    check("t5_exc_clear", exc_o, 0);
    handshake();
    all_respond(3'd4, 3'd4, 3'd4, 3'd4);
    check("t5_clean_id", trans_id_o, 4);
    check("t5_sticky", mismatch_o, 1);
    handshake();

    // Watchdog: only cluster 0 answers.
    set_slot(0, 64'hE0, 3'd1, 1'b0, 5'h00);
    clus_valid_i = 4'h1;
    tick();
    clus_valid_i = 4'h0;
    for (int i = 1; i <= 33; i++) begin
      tick();
      if (i == 15 || i == 17 || i == 31 || i == 33)
        check($sformatf("t6_quiet_%0d", i), timeout_o, 0);
      if (i == 16 || i == 32)
        check($sformatf("t6_pulse_%0d", i), timeout_o, 1);
    end
    check("t6_got_kept", clus_ready_o, 4'b1110);
    check("t6_no_valid", resp_valid_o, 0);

    // Reset mid-collection.
    #2 rst_i = 1'b1;
    #1;
    check("t7_result", result_o, 0);
    check("t7_mismatch", mismatch_o, 0);
    check("t7_valid", resp_valid_o, 0);
    check("t7_timeout", timeout_o, 0);
    tick();
    rst_i = 1'b0;
    tick();
    check("t7_ready", clus_ready_o, 4'hF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
